automat_secventiator: RTL and testbench

- Sequencing controller for the coffee vending datapath.
- Accumulates coin credit from the 1-leu and 5-lei sensors and checks it against a price.
- Hands off to the brewer with a ready/request handshake.
- Returns change and cancelled credit as 1-leu rest pulses.
- Sits between the coin sensors, cancel button and brewer unit; all outputs are registered (Moore).

---
 rtl/automat_secventiator.sv | 176 +++++++++++++++++
 tb/tb_automat_secventiator.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/automat_secventiator.sv
// Coffee vending sequencer: collects 1/5-lei coins, requests a brew, refunds change as 1-leu pulses.
// Latency: the coin completing the price enters VEND at that edge; cafea follows one edge later, then rest pulses.
// Backpressure: holds in VEND while brew_ready=0; coins outside COLLECT (or overflowing MAX_CREDIT) are refused.
// Optional sales counter output vanzari[7:0] is built when AUTOMAT_CONTOR_EN is defined.
module automat_secventiator #(
  parameter int unsigned PRET       = 3,
  parameter int unsigned MAX_CREDIT = 9,
  parameter int unsigned CREDIT_W   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                B1leu,
  input  logic                B5lei,
  input  logic                anulare,
  input  logic                brew_ready,
  output logic                cafea,
  output logic                rest,
  output logic                rejected,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
`ifdef AUTOMAT_CONTOR_EN
  ,
  output logic [7:0]          vanzari
`endif
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    VEND    = 2'd1,
    CHANGE  = 2'd2,
    GAP     = 2'd3
  } state_t;

  // Constants sized to the widened credit arithmetic so nothing wraps silently.
  localparam logic [CREDIT_W:0]   MAX_X  = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W:0]   PRET_X = (CREDIT_W+1)'(PRET);
  localparam logic [CREDIT_W:0]   ONE_X  = (CREDIT_W+1)'(1);
  localparam logic [CREDIT_W:0]   FIVE_X = (CREDIT_W+1)'(5);
  localparam logic [CREDIT_W-1:0] PRET_C = CREDIT_W'(PRET);
  localparam logic [CREDIT_W-1:0] ONE_C  = CREDIT_W'(1);

  state_t              state_q;
  logic [CREDIT_W-1:0] credit_q;
  logic                cafea_q;
  logic                rest_q;
  logic                rejected_q;
  logic                busy_q;

  logic [CREDIT_W:0]   credit_x;
  logic [CREDIT_W:0]   sum1_d;
  logic [CREDIT_W:0]   sum5_d;
  logic [CREDIT_W:0]   credit_coin_d;
  logic                coin_rej_d;
  logic                coin_any_d;
  logic                cancel_d;

  // Coin evaluation for COLLECT: 5 lei wins over 1 leu, and a coin that would overflow MAX_CREDIT is refused.
  always_comb begin
    credit_x      = {1'b0, credit_q};
    sum1_d        = credit_x + ONE_X;
    sum5_d        = credit_x + FIVE_X;
    coin_any_d    = B1leu | B5lei;
    cancel_d      = anulare && (credit_q != '0);
    credit_coin_d = credit_x;
    coin_rej_d    = 1'b0;
    if (B5lei) begin
      if (sum5_d <= MAX_X) begin
        credit_coin_d = sum5_d;
      end else begin
        coin_rej_d = 1'b1;
      end
      if (B1leu) begin
        coin_rej_d = 1'b1;
      end
    end else if (B1leu) begin
      if (sum1_d <= MAX_X) begin
        credit_coin_d = sum1_d;
      end else begin
        coin_rej_d = 1'b1;
      end
    end
  end

  // Main sequencer: state, credit and all Moore outputs registered together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= COLLECT;
      credit_q   <= '0;
      cafea_q    <= 1'b0;
      rest_q     <= 1'b0;
      rejected_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      cafea_q    <= 1'b0;
      rest_q     <= 1'b0;
      rejected_q <= 1'b0;
      case (state_q)
        COLLECT: begin
          if (cancel_d) begin
            // Cancel wins; any coin arriving alongside it is refused.
            rejected_q <= coin_any_d;
            state_q    <= CHANGE;
            busy_q     <= 1'b1;
          end else begin
            credit_q   <= credit_coin_d[CREDIT_W-1:0];
            rejected_q <= coin_rej_d;
            if (credit_coin_d >= PRET_X) begin
              state_q <= VEND;
              busy_q  <= 1'b1;
            end else begin
              busy_q  <= 1'b0;
            end
          end
        end
        VEND: begin
          rejected_q <= coin_any_d;
          if (brew_ready) begin
            cafea_q  <= 1'b1;
            credit_q <= credit_q - PRET_C;
            if (credit_x > PRET_X) begin
              state_q <= CHANGE;
              busy_q  <= 1'b1;
            end else begin
              state_q <= COLLECT;
              busy_q  <= 1'b0;
            end
          end
        end
        CHANGE: begin
          rejected_q <= coin_any_d;
          rest_q     <= 1'b1;
          credit_q   <= credit_q - ONE_C;
          state_q    <= GAP;
          busy_q     <= 1'b1;
        end
        GAP: begin
          // One low cycle between rest pulses, then either more change or back to idle.
          rejected_q <= coin_any_d;
          if (credit_q != '0) begin
            state_q <= CHANGE;
            busy_q  <= 1'b1;
          end else begin
            state_q <= COLLECT;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= COLLECT;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef AUTOMAT_CONTOR_EN
  logic [7:0] vanzari_q;

  // Saturating count of dispensed coffees, bumped on the edge that raises cafea.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vanzari_q <= 8'd0;
    end else if ((state_q == VEND) && brew_ready && (vanzari_q != 8'hFF)) begin
      vanzari_q <= vanzari_q + 8'd1;
    end
  end

  assign vanzari = vanzari_q;
`endif

  assign cafea    = cafea_q;
  assign rest     = rest_q;
  assign rejected = rejected_q;
  assign busy     = busy_q;
  assign credit   = credit_q;

endmodule

// File: tb/tb_automat_secventiator.sv
// Bench for automat_secventiator: directed scenarios plus random traffic against a credit/refund model.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same offset.
// A second instance with PRET=9 exercises the overflow-refusal corner.
module tb_automat_secventiator;

  localparam int PRET = 3;
  localparam int MAXC = 9;

  logic       clk = 1'b0;
  logic       reset;
  logic       rst9;
  logic       B1leu, B5lei, anulare, brew_ready;
  logic       cafea, rest, rejected, busy;
  logic [3:0] credit;
  logic       cafea9, rest9, rejected9, busy9;
  logic [3:0] credit9;
`ifdef AUTOMAT_CONTOR_EN
  logic [7:0] vanzari, vanzari9;
`endif

  always #5 clk = ~clk;

  automat_secventiator #(.PRET(PRET), .MAX_CREDIT(MAXC), .CREDIT_W(4)) dut (
    .clk(clk), .reset(reset), .B1leu(B1leu), .B5lei(B5lei), .anulare(anulare),
    .brew_ready(brew_ready), .cafea(cafea), .rest(rest), .rejected(rejected),
    .busy(busy), .credit(credit)
`ifdef AUTOMAT_CONTOR_EN
    , .vanzari(vanzari)
`endif
  );

  automat_secventiator #(.PRET(9), .MAX_CREDIT(9), .CREDIT_W(4)) dut9 (
    .clk(clk), .reset(rst9), .B1leu(B1leu), .B5lei(B5lei), .anulare(anulare),
    .brew_ready(brew_ready), .cafea(cafea9), .rest(rest9), .rejected(rejected9),
    .busy(busy9), .credit(credit9)
`ifdef AUTOMAT_CONTOR_EN
    , .vanzari(vanzari9)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: credit held, whether a brew is owed, and a refund in progress paced by a wait count.
  int m_credit, m_wait, m_sales;
  bit m_vend, m_refund;
  bit e_cafea, e_rest, e_rej;

  logic [7:0] dv;
  assign dv = {cafea, rest, rejected, busy, credit};

  function automatic logic [7:0] ev();
    return {e_cafea, e_rest, e_rej, (m_vend | m_refund), 4'(m_credit)};
  endfunction

  task automatic model_reset();
    m_credit = 0; m_wait = 0; m_sales = 0;
    m_vend = 0; m_refund = 0;
    e_cafea = 0; e_rest = 0; e_rej = 0;
  endtask

  task automatic model_step(input logic b1, input logic b5, input logic an, input logic br);
    e_cafea = 0; e_rest = 0; e_rej = 0;
    if (m_vend) begin
      e_rej = b1 | b5;
      if (br) begin
        e_cafea = 1;
        m_credit -= PRET;
        m_vend = 0;
        if (m_sales < 255) m_sales++;
        if (m_credit > 0) begin m_refund = 1; m_wait = 0; end
      end
    end else if (m_refund) begin
      e_rej = b1 | b5;
      if (m_wait > 0) begin
        m_wait--;
        if (m_credit == 0) m_refund = 0;
      end else begin
        e_rest = 1; m_credit--; m_wait = 1;
      end
    end else if (an && m_credit > 0) begin
      m_refund = 1; m_wait = 0; e_rej = b1 | b5;
    end else begin
      if (b5) begin
        if (m_credit + 5 <= MAXC) m_credit += 5; else e_rej = 1;
        if (b1) e_rej = 1;
      end else if (b1) begin
        if (m_credit + 1 <= MAXC) m_credit += 1; else e_rej = 1;
      end
      if (m_credit >= PRET) m_vend = 1;
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, settle for sampling.
  task automatic cycle(input logic b1, input logic b5, input logic an, input logic br);
    B1leu = b1; B5lei = b5; anulare = an; brew_ready = br;
    @(posedge clk);
    model_step(b1, b5, an, br);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (!(m_vend || m_refund)) break;
      cycle(0, 0, 0, 1);
      n_cmp++;
      if (dv !== ev()) begin n_fail++; $display("FAIL drain: got %b want %b", dv, ev()); end
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL drain_timeout: busy=%b want 0", busy); end
  endtask

  task automatic test_reset();
    reset = 1'b0; rst9 = 1'b0;
    B1leu = 0; B5lei = 0; anulare = 0; brew_ready = 0;
    model_reset();
    #3;
    n_cmp++;
    if (dv !== 8'h00) begin n_fail++; $display("FAIL reset_state: got %b want %b", dv, 8'h00); end
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0);
      n_cmp++;
      if (dv !== 8'h00) begin n_fail++; $display("FAIL reset_idle: got %b want %b", dv, 8'h00); end
    end
  endtask

  task automatic test_exact_price();
    drain();
    for (int k = 1; k <= 3; k++) begin
      cycle(1, 0, 0, 1);
      n_cmp++;
      if (dv !== ev() || credit !== 4'(k)) begin
        n_fail++; $display("FAIL exact_price_coin%0d: got %b want %b", k, dv, ev());
      end
    end
    cycle(0, 0, 0, 1);
    n_cmp++;
    if ({cafea, rest, busy, credit} !== 7'b1_0_0_0000) begin
      n_fail++; $display("FAIL exact_price_vend: got %b want 1000000", {cafea, rest, busy, credit});
    end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 1);
      n_cmp++;
      if (dv !== ev() || rest !== 1'b0) begin n_fail++; $display("FAIL exact_price_after: got %b want %b", dv, ev()); end
    end
  endtask

  task automatic test_change();
    logic [5:0] rest_seq, cafea_seq;
    drain();
    for (int i = 0; i < 6; i++) begin
      cycle(0, i == 0, 0, 1);
      rest_seq[5-i] = rest; cafea_seq[5-i] = cafea;
      n_cmp++;
      if (dv !== ev()) begin n_fail++; $display("FAIL change_cycle%0d: got %b want %b", i, dv, ev()); end
    end
    n_cmp++;
    if ({cafea_seq, rest_seq} !== {6'b010000, 6'b001010}) begin
      n_fail++; $display("FAIL change_pattern: got %b want %b", {cafea_seq, rest_seq}, {6'b010000, 6'b001010});
    end
    n_cmp++;
    if ({busy, credit} !== 5'b0) begin n_fail++; $display("FAIL change_idle: got %b want 00000", {busy, credit}); end
  endtask

  task automatic test_cancel();
    int n_rest = 0, n_caf = 0;
    drain();
    cycle(1, 0, 0, 1);
    n_cmp++;
    if (credit !== 4'd1) begin n_fail++; $display("FAIL cancel_credit: got %0d want 1", credit); end
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, i == 0, 1);
      n_rest += rest; n_caf += cafea;
      n_cmp++;
      if (dv !== ev()) begin n_fail++; $display("FAIL cancel_cycle%0d: got %b want %b", i, dv, ev()); end
    end
    n_cmp++;
    if (n_rest !== 1 || n_caf !== 0) begin
      n_fail++; $display("FAIL cancel_counts: got rest=%0d cafea=%0d want rest=1 cafea=0", n_rest, n_caf);
    end
  endtask

  task automatic test_stall();
    int n_rest = 0, n_caf = 0, n_rej = 0;
    drain();
    cycle(0, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(i == 4, 0, 0, 0);
      n_rej += rejected;
      n_cmp++;
      if (cafea !== 1'b0 || busy !== 1'b1 || credit !== 4'd5 || dv !== ev()) begin
        n_fail++; $display("FAIL stall_hold%0d: got %b want %b", i, dv, ev());
      end
    end
    n_cmp++;
    if (n_rej !== 1) begin n_fail++; $display("FAIL stall_reject: got %0d want 1", n_rej); end
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 0, 1);
      n_rest += rest; n_caf += cafea;
    end
    n_cmp++;
    if (n_caf !== 1 || n_rest !== 2 || busy !== 1'b0) begin
      n_fail++; $display("FAIL stall_release: got cafea=%0d rest=%0d busy=%b want 1 2 0", n_caf, n_rest, busy);
    end
  endtask

  task automatic test_simultaneous();
    int n_rest = 0, n_caf = 0, n_rej = 0;
    drain();
    cycle(1, 1, 0, 0);
    n_cmp++;
    if (credit !== 4'd5 || rejected !== 1'b1 || dv !== ev()) begin
      n_fail++; $display("FAIL simul_coin: got %b want %b", dv, ev());
    end
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 0, 1);
      n_rest += rest; n_caf += cafea; n_rej += rejected;
    end
    n_cmp++;
    if (n_caf !== 1 || n_rest !== 2 || n_rej !== 0) begin
      n_fail++; $display("FAIL simul_counts: got cafea=%0d rest=%0d rej=%0d want 1 2 0", n_caf, n_rest, n_rej);
    end
  endtask

  task automatic test_pret9();
    drain();
    rst9 = 1'b1;
    cycle(1, 1, 0, 0);
    n_cmp++;
    if ({credit9, rejected9, busy9, cafea9} !== {4'd5, 3'b100}) begin
      n_fail++; $display("FAIL p9_simul: got %b want %b", {credit9, rejected9, busy9, cafea9}, {4'd5, 3'b100});
    end
    cycle(0, 1, 0, 0);
    n_cmp++;
    if ({credit9, rejected9, busy9} !== {4'd5, 2'b10}) begin
      n_fail++; $display("FAIL p9_overflow: got %b want %b", {credit9, rejected9, busy9}, {4'd5, 2'b10});
    end
    cycle(0, 0, 0, 0);
    n_cmp++;
    if ({credit9, rejected9, busy9} !== {4'd5, 2'b00}) begin
      n_fail++; $display("FAIL p9_hold: got %b want %b", {credit9, rejected9, busy9}, {4'd5, 2'b00});
    end
    drain();
  endtask

  task automatic test_reset_midop();
    int n_rest = 0;
    drain();
    cycle(0, 1, 0, 1);
    cycle(0, 0, 0, 1);
    n_cmp++;
    if ({cafea, busy, credit} !== {2'b11, 4'd2}) begin
      n_fail++; $display("FAIL midop_setup: got %b want %b", {cafea, busy, credit}, {2'b11, 4'd2});
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (dv !== 8'h00) begin n_fail++; $display("FAIL midop_async: got %b want %b", dv, 8'h00); end
    model_reset();
    #2 reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 0, 1);
      n_rest += rest;
      n_cmp++;
      if (dv !== ev()) begin n_fail++; $display("FAIL midop_after%0d: got %b want %b", i, dv, ev()); end
    end
    n_cmp++;
    if (n_rest !== 0) begin n_fail++; $display("FAIL midop_rest: got %0d want 0", n_rest); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom % 4) == 0, ($urandom % 6) == 0, ($urandom % 12) == 0, ($urandom % 3) != 0);
      n_cmp++;
      if (dv !== ev()) begin n_fail++; $display("FAIL random_cycle%0d: got %b want %b", i, dv, ev()); end
`ifdef AUTOMAT_CONTOR_EN
      n_cmp++;
      if (vanzari !== 8'(m_sales)) begin n_fail++; $display("FAIL random_sales%0d: got %0d want %0d", i, vanzari, m_sales); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_exact_price();
    test_change();
    test_cancel();
    test_stall();
    test_simultaneous();
    test_pret9();
    test_reset_midop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
